dcache_ctrl: RTL

- MEM-stage data cache controller.
- Serves the load/store request held in the EX/MEM pipeline register.
- Generates the dcache_stall that freezes the pipeline.
- Direct-mapped, write-through, no-write-allocate; 4-word lines refilled from backing memory over a req/ack + beat interface.

---
 rtl/dcache_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// MEM-stage direct-mapped, write-through, no-write-allocate data cache controller.
// Define DCACHE_PERF_EN to add the perf_hits / perf_misses counters.
module dcache_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int INDEX_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_mem_read,
    input  logic              cpu_mem_write,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_unsigned,
    output logic [31:0]       cpu_rdata,
    output logic              dcache_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
`endif
);

    localparam int TAG_W = ADDR_W - 4 - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

    state_t            state;
    logic [31:0]       data_mem [0:4*LINES-1];
    logic [TAG_W-1:0]  tag_mem  [0:LINES-1];
    logic [LINES-1:0]  valid;
    logic [1:0]        beat_cnt;

    logic              is_write;
    logic              is_read;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        offset;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]  tag;
    logic              hit;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       st_wdata;
    logic [3:0]        st_wstrb;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[31:ADDR_W];

    // A simultaneous read and write is handled as a write.
    assign is_write = cpu_mem_write;
    assign is_read  = cpu_mem_read & ~cpu_mem_write;

    always_comb begin
        addr = cpu_addr[ADDR_W-1:0];
        if (cpu_size == 2'b01)
            addr[0] = 1'b0;
        else if (cpu_size[1])
            addr[1:0] = 2'b00;
    end

    assign offset  = addr[3:2];
    assign index   = addr[4+INDEX_W-1:4];
    assign tag     = addr[ADDR_W-1:4+INDEX_W];
    assign hit     = valid[index] && (tag_mem[index] == tag);
    assign rd_word = data_mem[{index, offset}];
    assign rd_byte = rd_word[{addr[1:0], 3'b000} +: 8];
    assign rd_half = rd_word[{addr[1], 4'b0000} +: 16];

    always_comb begin
        cpu_rdata = 32'h0;
        if (is_read) begin
            case (cpu_size)
                2'b00:   cpu_rdata = {{24{~cpu_unsigned & rd_byte[7]}}, rd_byte};
                2'b01:   cpu_rdata = {{16{~cpu_unsigned & rd_half[15]}}, rd_half};
                default: cpu_rdata = rd_word;
            endcase
        end
    end

    always_comb begin
        st_wdata = cpu_wdata;
        st_wstrb = 4'b1111;
        case (cpu_size)
            2'b00: begin
                st_wdata = {4{cpu_wdata[7:0]}};
                st_wstrb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{cpu_wdata[15:0]}};
                st_wstrb = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Stall is forced low under reset so an abandoned miss releases the pipeline at once.
    assign dcache_stall = reset &&
                          ((state == REFILL) || (state == WRITE) ||
                           ((state == IDLE) && (is_write || (is_read && !hit))));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            beat_cnt  <= 2'd0;
            valid     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_write) begin
                        state     <= WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        mem_wdata <= st_wdata;
                        mem_wstrb <= st_wstrb;
                    end else if (is_read && !hit) begin
                        state        <= REFILL;
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr     <= {addr[ADDR_W-1:4], 4'b0000};
                        beat_cnt     <= 2'd0;
                        valid[index] <= 1'b0;
                    end
                end
                REFILL: begin
                    if (mem_req && mem_ack)
                        mem_req <= 1'b0;
                    if (mem_rvalid) begin
                        beat_cnt <= beat_cnt + 2'd1;
                        if (beat_cnt == 2'd3) begin
                            valid[index] <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_req && mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Storage arrays need no reset; the valid bits alone decide what is usable.
    always_ff @(posedge clk) begin
        if (state == REFILL && mem_rvalid) begin
            data_mem[{index, beat_cnt}] <= mem_rdata;
            if (beat_cnt == 2'd3)
                tag_mem[index] <= tag;
        end
        if (state == WRITE && mem_req && mem_ack && hit) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b])
                    data_mem[{index, offset}][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

`ifdef DCACHE_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_hits   <= 32'h0;
            perf_misses <= 32'h0;
        end else if (state == IDLE && is_read) begin
            if (hit)
                perf_hits <= perf_hits + 32'h1;
            else
                perf_misses <= perf_misses + 32'h1;
        end
    end
`endif

endmodule
